// File: rtl/rv32i_tohost_ctrl_pkg.sv
// Shared types and constants for the RV32I bench completion logic.
// Store-event bundle, tohost address, FSM state and verdict enums.
package rv32i_tohost_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] TOHOST_ADDR = 32'h8000_0000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200_000;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } store_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } tb_ctrl_state_e;

  typedef enum logic [1:0] {
    VD_NONE,
    VD_PASS,
    VD_FAIL,
    VD_TIMEOUT
  } tohost_verdict_e;

endpackage

// File: rtl/rv32i_tb_event_fifo.sv
// Store-event FIFO, first-word fall-through, wrap-bit pointers.
// Ports: clk, rst_n, push/wdata/full, pop/rdata/empty.
module rv32i_tb_event_fifo #(
  parameter int DEPTH = 8,
  parameter type T = logic [63:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  output logic full,
  input  logic pop,
  output T     rdata,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves
  assign do_push = push && (!full || do_pop);

  // Masked head keeps the output at zero while empty
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv32i_tohost_ctrl.sv
// Test-completion controller: tohost decode, cycle budget, store FIFO.
// Ports: start, store snoop, event drain handshake, verdict/status.
module rv32i_tohost_ctrl
  import rv32i_tohost_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0] TOHOST = TOHOST_ADDR
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            st_valid_i,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output store_event_t    ev_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic            timeout_o,
  output logic [30:0]     exit_code_o,
  output logic [31:0]     cycle_count_o,
  output logic            overflow_o
);

  tb_ctrl_state_e  state;
  tohost_verdict_e verdict;

  logic         tohost_hit;
  logic         term;
  logic         enq;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  cnt_nxt;
  logic         expire;
  store_event_t st_ev;

  assign tohost_hit = st_valid_i && (st_addr_i == TOHOST);
  assign term       = tohost_hit && st_data_i[0];
  // tohost writes never enter the FIFO, terminating or not
  assign enq        = (state == ST_RUN) && st_valid_i && !tohost_hit;
  assign pop        = ev_valid_o && ev_ready_i;
  assign cnt_nxt    = cycle_count_o + 32'd1;
  assign expire     = (cnt_nxt == 32'(TIMEOUT_CYCLES));
  assign st_ev      = '{addr: st_addr_i, data: st_data_i};

  rv32i_tb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (store_event_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (enq),
    .wdata (st_ev),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (ev_o),
    .empty (fifo_empty)
  );

  assign ev_valid_o = !fifo_empty;
  assign pass_o     = (verdict == VD_PASS);
  assign fail_o     = (verdict == VD_FAIL);
  assign timeout_o  = (verdict == VD_TIMEOUT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      verdict       <= VD_NONE;
      exit_code_o   <= '0;
      cycle_count_o <= '0;
      overflow_o    <= 1'b0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (enq && fifo_full && !pop) overflow_o <= 1'b1;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state         <= ST_RUN;
            busy_o        <= 1'b1;
            verdict       <= VD_NONE;
            exit_code_o   <= '0;
            cycle_count_o <= '0;
            overflow_o    <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_count_o <= cnt_nxt;
          // A terminating write beats a simultaneous timeout
          if (term) begin
            state       <= ST_DRAIN;
            exit_code_o <= st_data_i[31:1];
            verdict     <= (st_data_i[31:1] == '0) ? VD_PASS : VD_FAIL;
          end else if (expire) begin
            state   <= ST_DRAIN;
            verdict <= VD_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
